// File: rtl/eth_sw_pkg.sv
// Shared switch-datapath definitions: arbiter state encoding, default timing
// constants and an index-width helper used by the receive/transmit arbiters.
package eth_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_GAP_CYCLES = 12;
  localparam int unsigned DEF_TIMEOUT    = 64;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
// Returns one-hot winner, its index and whether any request was present.
module rr_arb_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = ptr;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
      cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/eth_rx_port_arbiter.sv
// Round-robin frame arbiter merging NUM_PORTS receive streams onto one path.
// Optional frame/abort counters are enabled with `define ETH_RX_ARB_STATS_EN.
module eth_rx_port_arbiter
  import eth_sw_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic [NUM_PORTS-1:0]         i_valid,
  input  logic [NUM_PORTS-1:0]         i_last,
  input  logic [NUM_PORTS-1:0]         i_er,
  input  logic [8*NUM_PORTS-1:0]       i_data,
  output logic [NUM_PORTS-1:0]         o_ready,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic                         o_last,
  output logic                         o_er,
  output logic [7:0]                   o_data,
  output logic [NUM_PORTS-1:0]         o_grant,
  output logic [$clog2(NUM_PORTS)-1:0] o_sel,
  output logic                         o_busy,
`ifdef ETH_RX_ARB_STATS_EN
  output logic [15:0]                  o_frame_cnt,
  output logic [15:0]                  o_abort_cnt,
`endif
  output logic                         o_abort
);

  localparam int unsigned SW = $clog2(NUM_PORTS);
  localparam int unsigned WW = idx_width(TIMEOUT);
  localparam int unsigned GW = idx_width(GAP_CYCLES);

  arb_state_t           state, state_nxt;
  logic [NUM_PORTS-1:0] grant_q, grant_nxt;
  logic [SW-1:0]        sel_q, sel_nxt;
  logic [SW-1:0]        ptr_q, ptr_nxt;
  logic [WW-1:0]        wd_q, wd_nxt;
  logic [GW-1:0]        gap_q, gap_nxt;
  logic                 abort_q, abort_nxt;
  logic                 end_frame, xfer;

  logic [NUM_PORTS-1:0] pick_grant;
  logic [SW-1:0]        pick_idx;
  logic                 pick_any;

  rr_arb_pick #(
    .N (NUM_PORTS),
    .W (SW)
  ) u_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is only non-zero in XFER, so masking with it also gates by state.
  always_comb begin
    o_valid = |(grant_q & i_valid);
    o_last  = |(grant_q & i_last);
    o_er    = |(grant_q & i_er);
    o_data  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      o_data = o_data | ({8{grant_q[p]}} & i_data[8*p +: 8]);
    end
  end

  assign o_ready = grant_q & {NUM_PORTS{i_ready}};
  assign xfer    = o_valid & i_ready;
  assign o_grant = grant_q;
  assign o_sel   = sel_q;
  assign o_busy  = (state != ST_IDLE);
  assign o_abort = abort_q;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr_q;
    wd_nxt    = wd_q;
    gap_nxt   = gap_q;
    abort_nxt = 1'b0;
    end_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_XFER;
          grant_nxt = pick_grant;
          sel_nxt   = pick_idx;
          ptr_nxt   = (pick_idx == SW'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
          wd_nxt    = '0;
        end
      end
      ST_XFER: begin
        // A terminating transfer takes priority over a coincident timeout.
        if (xfer && (o_last || o_er)) begin
          end_frame = 1'b1;
        end else if (xfer) begin
          wd_nxt = '0;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          end_frame = 1'b1;
          abort_nxt = 1'b1;
        end else begin
          wd_nxt = wd_q + 1'b1;
        end
        if (end_frame) begin
          grant_nxt = '0;
          wd_nxt    = '0;
          if (GAP_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = GW'(GAP_CYCLES - 1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_nxt = ST_IDLE;
        else             gap_nxt   = gap_q - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      sel_q   <= sel_nxt;
      ptr_q   <= ptr_nxt;
      wd_q    <= wd_nxt;
      gap_q   <= gap_nxt;
      abort_q <= abort_nxt;
    end
  end

`ifdef ETH_RX_ARB_STATS_EN
  // Error-terminated frames are tallied with timeouts, not as good frames.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_abort_cnt <= '0;
    end else begin
      if (xfer && o_last && !o_er && o_frame_cnt != 16'hFFFF)
        o_frame_cnt <= o_frame_cnt + 16'd1;
      if ((abort_nxt || (xfer && o_er)) && o_abort_cnt != 16'hFFFF)
        o_abort_cnt <= o_abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eth_rx_port_arbiter.sv
// Directed self-checking bench for eth_rx_port_arbiter (4 ports, gap 12, timeout 64).
module tb_eth_rx_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req, i_valid, i_last, i_er, o_ready, o_grant;
  logic [31:0] i_data;
  logic        i_ready, o_valid, o_last, o_er, o_busy, o_abort;
  logic [7:0]  o_data;
  logic [1:0]  o_sel;
`ifdef ETH_RX_ARB_STATS_EN
  logic [15:0] o_frame_cnt, o_abort_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  eth_rx_port_arbiter #(
    .NUM_PORTS  (4),
    .GAP_CYCLES (12),
    .TIMEOUT    (64)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_er    (i_er),
    .i_data  (i_data),
    .o_ready (o_ready),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_er    (o_er),
    .o_data  (o_data),
    .o_grant (o_grant),
    .o_sel   (o_sel),
    .o_busy  (o_busy),
`ifdef ETH_RX_ARB_STATS_EN
    .o_frame_cnt (o_frame_cnt),
    .o_abort_cnt (o_abort_cnt),
`endif
    .o_abort (o_abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_stats(input int frames, input int aborts);
`ifdef ETH_RX_ARB_STATS_EN
    check("frame_cnt", 32'(o_frame_cnt), 32'(frames));
    check("abort_cnt", 32'(o_abort_cnt), 32'(aborts));
`else
    if (frames < 0 || aborts < 0) $display("bad stats args");
`endif
  endtask

  // Drives n bytes on port p (other lanes carry decoy valid/last/er/data).
  // term: 0 = frame left open, 1 = ends with last, 2 = ends with er.
  task automatic send_frame(input int p, input int n, input logic [7:0] base, input int term);
    logic [3:0] oh;
    logic [7:0] v;
    logic       lb, eb;
    oh = '0;
    oh[p] = 1'b1;
    for (int b = 0; b < n; b++) begin
      v  = base + 8'(b);
      lb = (b == n - 1) && (term == 1);
      eb = (b == n - 1) && (term == 2);
      i_ready = 1'b1;
      i_valid = 4'b1111;
      i_last  = 4'b1111;
      i_er    = 4'b1111;
      i_last[p] = lb;
      i_er[p]   = eb;
      i_data  = 32'h5A5A5A5A;
      i_data[8*p +: 8] = v;
      #1;
      check("byte_valid", 32'(o_valid), 32'h1);
      check("byte_data", 32'(o_data), 32'(v));
      check("byte_ready", 32'(o_ready), 32'(oh));
      check("byte_last", 32'(o_last), 32'(lb));
      check("byte_er", 32'(o_er), 32'(eb));
      cyc();
    end
    i_valid = '0;
    i_last  = '0;
    i_er    = '0;
    if (term != 0) check("grant_after_end", 32'(o_grant), 32'h0);
    else           check("grant_held", 32'(o_grant), 32'(oh));
  endtask

  // Called on the first gap cycle; walks the 12-cycle gap and expects port p next.
  task automatic gap_and_grant(input int p);
    logic [3:0] oh;
    oh = '0;
    oh[p] = 1'b1;
    cyc();
    check("abort_low_in_gap", 32'(o_abort), 32'h0);
    repeat (10) cyc();
    check("busy_last_gap", 32'(o_busy), 32'h1);
    check("grant_last_gap", 32'(o_grant), 32'h0);
    cyc();
    check("busy_idle", 32'(o_busy), 32'h0);
    cyc();
    check("next_grant", 32'(o_grant), 32'(oh));
    check("next_sel", 32'(o_sel), 32'(p));
    check("next_busy", 32'(o_busy), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int idx;
    i_rst = 1'b1; i_req = '0; i_valid = '0; i_last = '0; i_er = '0;
    i_data = '0; i_ready = 1'b0;
    repeat (3) cyc();
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_sel", 32'(o_sel), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_abort", 32'(o_abort), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_ready", 32'(o_ready), 32'h0);

    // Two requesters from pointer 0, then the other after the gap.
    i_rst = 1'b0;
    i_req = 4'b0101;
    cyc();
    check("first_grant", 32'(o_grant), 32'h1);
    check("first_sel", 32'(o_sel), 32'h0);
    send_frame(0, 10, 8'hA0, 1);
    i_req = 4'b0100;
    gap_and_grant(2);
    send_frame(2, 1, 8'hC0, 1);

    // Reset during gap, then all ports requesting: 0,1,2,3,0.
    i_rst = 1'b1;
    i_req = 4'b1111;
    cyc();
    check("rst_gap_grant", 32'(o_grant), 32'h0);
    check("rst_gap_busy", 32'(o_busy), 32'h0);
    i_rst = 1'b0;
    cyc();
    check("rr_first_grant", 32'(o_grant), 32'h1);
    for (int k = 0; k < 5; k++) begin
      send_frame(k % 4, 3, 8'h40 + 8'(16 * k), 1);
      gap_and_grant((k + 1) % 4);
    end
    check_stats(5, 0);

    // Port 1 stalls mid-frame for the full watchdog period.
    i_req = 4'b1101;
    send_frame(1, 2, 8'h30, 0);
    repeat (63) cyc();
    check("wd_no_abort_yet", 32'(o_abort), 32'h0);
    check("wd_grant_held", 32'(o_grant), 32'h2);
    cyc();
    check("wd_abort", 32'(o_abort), 32'h1);
    check("wd_grant_drop", 32'(o_grant), 32'h0);
    check("wd_busy", 32'(o_busy), 32'h1);
    check_stats(5, 1);
    gap_and_grant(2);

    // 40-byte frame with downstream ready toggling each cycle (80 cycles).
    idx = 0;
    for (int c = 0; c < 200 && idx < 40; c++) begin
      i_ready = (c % 2 == 1);
      i_valid = 4'b0100;
      i_last  = '0;
      i_last[2] = (idx == 39);
      i_data  = '0;
      i_data[23:16] = 8'h10 + 8'(idx);
      #1;
      check("tog_data", 32'(o_data), 32'h10 + 32'(idx));
      check("tog_ready", 32'(o_ready), i_ready ? 32'h4 : 32'h0);
      check("tog_no_abort", 32'(o_abort), 32'h0);
      if (i_ready) idx++;
      cyc();
    end
    i_valid = '0;
    i_last  = '0;
    check("tog_byte_count", 32'(idx), 32'd40);
    check("tog_grant_drop", 32'(o_grant), 32'h0);
    check_stats(6, 1);
    gap_and_grant(3);

    // Error on the fifth byte ends the frame without an abort pulse.
    send_frame(3, 5, 8'h70, 2);
    check("er_busy", 32'(o_busy), 32'h1);
    check("er_no_abort", 32'(o_abort), 32'h0);
    check_stats(6, 2);
    gap_and_grant(0);

    // Reset mid-frame drops grant at once; pointer restarts at 0.
    send_frame(0, 2, 8'h90, 0);
    i_rst   = 1'b1;
    i_valid = 4'b1111;
    i_ready = 1'b1;
    cyc();
    check("mid_rst_grant", 32'(o_grant), 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'h0);
    check("mid_rst_abort", 32'(o_abort), 32'h0);
    check("mid_rst_sel", 32'(o_sel), 32'h0);
    check("mid_rst_valid", 32'(o_valid), 32'h0);
    check("mid_rst_ready", 32'(o_ready), 32'h0);
    check_stats(0, 0);
    i_rst   = 1'b0;
    i_valid = '0;
    i_req   = 4'b1010;
    cyc();
    check("post_rst_grant", 32'(o_grant), 32'h2);
    check("post_rst_sel", 32'(o_sel), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
